// File: rtl/vec_collector.sv
// Collects three serial multiplier results into one vector word (elements, sum, argmax)
// and buffers it in a small drop-on-full FIFO. Optional drop counter: VEC_COLLECTOR_DROPCNT_EN.
module vec_collector #(
    parameter int DW    = 10,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3*DW-1:0]   out_vec,
    output logic [DW+1:0]     out_sum,
    output logic [1:0]        out_maxidx,
    output logic [AW:0]       level,
`ifdef VEC_COLLECTOR_DROPCNT_EN
    output logic [7:0]        drop_cnt,
`endif
    output logic              ovf
);

    typedef enum logic [1:0] {GOT0 = 2'd0, GOT1 = 2'd1, GOT2 = 2'd2} elem_state_t;

    typedef struct packed {
        logic [1:0]      maxidx;
        logic [DW+1:0]   sum;
        logic [3*DW-1:0] vec;
    } entry_t;

    elem_state_t       elem_cnt;
    logic [DW-1:0]     e0, e1;
    logic [AW:0]       wr_ptr, rd_ptr;
    entry_t            mem [DEPTH];
    entry_t            word_c, head;

    logic              complete, full, empty, pop, push, drop;
    logic [DW-1:0]     max01;
    logic [1:0]        idx01;

    // Assemble the completed word from the two captured elements plus the live third one.
    always_comb begin
        max01 = e0;
        idx01 = 2'd0;
        if (e1 > e0) begin
            max01 = e1;
            idx01 = 2'd1;
        end
        word_c.vec    = {in_data, e1, e0};
        word_c.sum    = (DW+2)'(e0) + (DW+2)'(e1) + (DW+2)'(in_data);
        word_c.maxidx = (in_data > max01) ? 2'd2 : idx01;
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign out_valid = !empty;
    assign complete = (elem_cnt == GOT2) && in_valid && !flush;
    assign pop      = out_valid && out_ready && !flush;
    // A full FIFO still takes the word when the head leaves on the same edge.
    assign push     = complete && (!full || pop);
    assign drop     = complete && full && !pop;

    assign head       = mem[rd_ptr[AW-1:0]];
    assign out_vec    = head.vec;
    assign out_sum    = head.sum;
    assign out_maxidx = head.maxidx;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= word_c;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            elem_cnt <= GOT0;
            e0       <= '0;
            e1       <= '0;
        end else if (flush) begin
            elem_cnt <= GOT0;
        end else if (in_valid) begin
            case (elem_cnt)
                GOT0: begin
                    e0       <= in_data;
                    elem_cnt <= GOT1;
                end
                GOT1: begin
                    e1       <= in_data;
                    elem_cnt <= GOT2;
                end
                default: elem_cnt <= GOT0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
            if (drop)
                ovf <= 1'b1;
        end
    end

`ifdef VEC_COLLECTOR_DROPCNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop_cnt <= '0;
        else if (flush)
            drop_cnt <= '0;
        else if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_vec_collector.sv
// Directed bench for vec_collector: table of single-vector cases plus
// hand-written full/drop, simultaneous push/pop, flush, reset and gap sequences.
module tb_vec_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [9:0]  in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_vec;
    logic [11:0] out_sum;
    logic [1:0]  out_maxidx;
    logic [2:0]  level;
    logic        ovf;
`ifdef VEC_COLLECTOR_DROPCNT_EN
    logic [7:0]  drop_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    vec_collector dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vec    (out_vec),
        .out_sum    (out_sum),
        .out_maxidx (out_maxidx),
        .level      (level),
`ifdef VEC_COLLECTOR_DROPCNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  a, b, c;
        logic [29:0] vec;
        logic [11:0] sum;
        logic [1:0]  mi;
    } vec_t;

    vec_t tbl [6];
    logic [29:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic elem(input logic [9:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Three back-to-back elements; returns at the negedge after the third is sampled.
    task automatic send3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        elem(a);
        elem(b);
        elem(c);
        idle(1);
    endtask

    function automatic logic [29:0] fv(input int k);
        logic [9:0] a, b, c;
        a = 10'(10 * k + 1);
        b = 10'(10 * k + 2);
        c = 10'(10 * k + 3);
        return {c, b, a};
    endfunction

    task automatic send_fv(input int k);
        send3(10'(10 * k + 1), 10'(10 * k + 2), 10'(10 * k + 3));
    endtask

    // Pop everything in exp_q in order, one word per cycle, then expect empty.
    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            chk({tag, " drain valid"}, 64'(out_valid), 64'd1);
            chk({tag, " drain vec"}, 64'(out_vec), 64'(exp_q.pop_front()));
            @(negedge clk);
        end
        chk({tag, " drain empty"}, 64'(out_valid), 64'd0);
        chk({tag, " drain level"}, 64'(level), 64'd0);
    endtask

    initial begin
        tbl[0] = '{10'd5,    10'd7,    10'd9,    {10'd9, 10'd7, 10'd5},          12'd21,   2'd2};
        tbl[1] = '{10'd8,    10'd8,    10'd3,    {10'd3, 10'd8, 10'd8},          12'd19,   2'd0};
        tbl[2] = '{10'd1023, 10'd1023, 10'd1023, {10'd1023, 10'd1023, 10'd1023}, 12'd3069, 2'd0};
        tbl[3] = '{10'd3,    10'd9,    10'd9,    {10'd9, 10'd9, 10'd3},          12'd21,   2'd1};
        tbl[4] = '{10'd0,    10'd0,    10'd0,    {10'd0, 10'd0, 10'd0},          12'd0,    2'd0};
        tbl[5] = '{10'd2,    10'd1,    10'd7,    {10'd7, 10'd1, 10'd2},          12'd10,   2'd2};

        rst = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
        #12;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset level", 64'(level), 64'd0);
        chk("reset ovf", 64'(ovf), 64'd0);
`ifdef VEC_COLLECTOR_DROPCNT_EN
        chk("reset drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            send3(tbl[i].a, tbl[i].b, tbl[i].c);
            chk($sformatf("t%0d valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("t%0d vec", i), 64'(out_vec), 64'(tbl[i].vec));
            chk($sformatf("t%0d sum", i), 64'(out_sum), 64'(tbl[i].sum));
            chk($sformatf("t%0d maxidx", i), 64'(out_maxidx), 64'(tbl[i].mi));
            chk($sformatf("t%0d level", i), 64'(level), 64'd1);
            @(negedge clk);
            chk($sformatf("t%0d popped level", i), 64'(level), 64'd0);
            chk($sformatf("t%0d popped valid", i), 64'(out_valid), 64'd0);
        end

        // Fill with consumer stalled, fifth vector dropped.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_fv(k);
            exp_q.push_back(fv(k));
        end
        chk("full level", 64'(level), 64'd4);
        chk("full ovf", 64'(ovf), 64'd0);
        send_fv(4);
        chk("drop level", 64'(level), 64'd4);
        chk("drop ovf", 64'(ovf), 64'd1);
`ifdef VEC_COLLECTOR_DROPCNT_EN
        chk("drop_cnt", 64'(drop_cnt), 64'd1);
`endif
        drain("drop");
        chk("ovf sticky", 64'(ovf), 64'd1);

        // Push into a full FIFO on the same edge as a pop.
        out_ready = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush clears ovf", 64'(ovf), 64'd0);
`ifdef VEC_COLLECTOR_DROPCNT_EN
        chk("flush clears drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        for (int k = 0; k < 4; k++) begin
            send_fv(k);
            if (k > 0) exp_q.push_back(fv(k));
        end
        elem(10'd51);
        elem(10'd52);
        elem(10'd53);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_q.push_back({10'd53, 10'd52, 10'd51});
        chk("pushpop level", 64'(level), 64'd4);
        chk("pushpop ovf", 64'(ovf), 64'd0);
        drain("pushpop");

        // Flush discards a partial vector and queued words.
        out_ready = 1'b0;
        send3(10'd100, 10'd200, 10'd300);
        elem(10'd4);
        elem(10'd6);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 10'd99;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush out_valid", 64'(out_valid), 64'd0);
        chk("flush level", 64'(level), 64'd0);
        send3(10'd1, 10'd2, 10'd3);
        chk("postflush level", 64'(level), 64'd1);
        chk("postflush vec", 64'(out_vec), 64'({10'd3, 10'd2, 10'd1}));
        chk("postflush sum", 64'(out_sum), 64'd6);
        exp_q.push_back({10'd3, 10'd2, 10'd1});
        drain("flush");

        // Async reset mid-vector with a word queued.
        out_ready = 1'b0;
        send3(10'd100, 10'd200, 10'd300);
        elem(10'd4);
        elem(10'd6);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midreset out_valid", 64'(out_valid), 64'd0);
        chk("midreset level", 64'(level), 64'd0);
        @(negedge clk);
        chk("inreset out_valid", 64'(out_valid), 64'd0);
        rst = 1'b1;
        send3(10'd1, 10'd2, 10'd3);
        chk("postreset level", 64'(level), 64'd1);
        chk("postreset vec", 64'(out_vec), 64'({10'd3, 10'd2, 10'd1}));
        chk("postreset sum", 64'(out_sum), 64'd6);
        exp_q.push_back({10'd3, 10'd2, 10'd1});
        drain("reset");

        // Gaps between elements.
        out_ready = 1'b1;
        elem(10'd5);
        idle(3);
        elem(10'd7);
        idle(1);
        chk("gap no early push", 64'(out_valid), 64'd0);
        chk("gap level", 64'(level), 64'd0);
        elem(10'd9);
        idle(1);
        chk("gap valid", 64'(out_valid), 64'd1);
        chk("gap vec", 64'(out_vec), 64'({10'd9, 10'd7, 10'd5}));
        chk("gap sum", 64'(out_sum), 64'd21);
        chk("gap maxidx", 64'(out_maxidx), 64'd2);
        chk("gap level", 64'(level), 64'd1);
        @(negedge clk);
        chk("gap popped", 64'(level), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vec_collector.md
Name: vec_collector

Overview:
- Downstream stage of the 3x3 constant-matrix multiplier.
- Captures the three serial 10-bit results the multiplier emits per input vector (valid high for 3 consecutive cycles).
- Packs them into one vector word, adds the element sum and the index of the largest element, and buffers the word in a small FIFO.
- The consumer drains the FIFO through a valid/ready handshake. The multiplier cannot be stalled, so a vector that arrives when the FIFO is full is dropped and flagged.

Parameters:
- DW, 10, element width (matches multiplier output).
- DEPTH, 4, FIFO depth in vectors; power of 2, minimum 2.
- AW, 2, log2(DEPTH).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  element strobe (multiplier valid).
- in_data  input  DW  element value (multiplier multout).
- flush  input  1  synchronous clear of partial vector, FIFO and ovf.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head word.
- out_vec  output  3*DW  {e2,e1,e0}; e0 is the first element received, in the LSBs.
- out_sum  output  DW+2  e0+e1+e2.
- out_maxidx  output  2  index of the largest element, 0..2.
- level  output  AW+1  FIFO occupancy, 0..DEPTH.
- ovf  output  1  sticky drop flag.

Behaviour:
- Reset (rst low, async): elem_cnt=0, e0=e1=0, FIFO empty, ptrs=0, out_valid=0, level=0, ovf=0. The data outputs present the memory entry at rd_ptr; they are don't-care while out_valid=0.
- Element FSM, states by elem_cnt:
  - GOT0 -> GOT1 -> GOT2 -> GOT0, advancing only on in_valid.
  - In GOT0, in_data is captured to e0. In GOT1, in_data is captured to e1.
  - In GOT2 there is no capture. The vector completes on this edge using {in_data, e1, e0}.
  - When in_valid is low, the state and captured elements hold. Gaps are legal; no timeout.
- Completion (GOT2 && in_valid && !flush):
  - Sum: e0+e1+in_data, computed in DW+2 bits with no overflow (maximum 3069).
  - Maxidx: strict greater-than compare, so on a tie the lowest index wins.
  - The word is written into the FIFO on the same edge.
- Latency: the third element is sampled at edge N. If the FIFO was empty, out_valid is high in the cycle after edge N.
- Pop: occurs when out_valid && out_ready. rd_ptr advances and the next entry appears the following cycle. out_ready while empty has no effect.
- Push accepted when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle. In that case level is unchanged and order is preserved.
- Drop: completion with level==DEPTH and no pop. The vector is discarded, ovf is set to 1, and the FIFO is unchanged. elem_cnt still returns to GOT0.
- ovf clears only on flush or reset.
- Pointers are AW+1 bits.
  - empty: ptrs equal.
  - full: MSBs differ and the low bits are equal.
  - Wrap-around is natural binary.
- flush has priority over in_valid, push and pop in the same cycle:
  - elem_cnt=0; ptrs=0; ovf=0.
  - The element on in_data that cycle is discarded.
  - out_valid is 0 in the next cycle.
- Reset mid-vector or mid-drain: everything is cleared immediately and no partial vector survives.
- level is registered and equals wr_ptr-rd_ptr.

Optional Feature:
- Macro: VEC_COLLECTOR_DROPCNT_EN.
- Defined: adds output port drop_cnt, 8 bits.
  - Increments on every dropped vector and saturates at 255.
  - Cleared by reset and by flush.
- Undefined: the port and its logic are absent. ovf behaviour is identical in both builds.

Test Plan:
- Reset with out_ready=1, then in_valid on 3 consecutive cycles with 5,7,9 -> one cycle after the third element: out_valid=1, out_vec={9,7,5}, out_sum=21, out_maxidx=2, level=1. The pop drops level to 0.
- Elements 8,8,3 -> out_maxidx=0, out_sum=19. Elements 1023,1023,1023 -> out_sum=3069, out_maxidx=0.
- out_ready=0, 5 vectors sent -> level=4 after the 4th; the 5th is dropped and ovf=1 (drop_cnt=1 if enabled). Raising out_ready yields the first 4 vectors in order, then out_valid=0; ovf remains 1.
- FIFO full, with the 3rd element of a new vector on the same cycle as out_ready=1 -> push accepted, level stays 4, ovf stays 0, and the new vector drains last.
- Elements 4,6 then flush, then 1,2,3 -> single FIFO entry {3,2,1} with sum 6. Repeat with rst pulled low after 2 elements -> same result, and out_valid=0 during reset.
- Gap insertion: 5, idle 3 cycles, 7, idle 1 cycle, 9 -> identical result to the first scenario; no push before the third element.
